// File: rtl/fetch_decode_unit.sv
// Fetch/decode front end: PC, IF/ID register, main control decode,
// load-use hazard detection, branch flush and perf counters.
module fetch_decode_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_data,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    output logic [31:0]      instr,
    output logic [1:0]       WBID,
    output logic [2:0]       MEID,
    output logic [3:0]       EXID,
    output logic             stall,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    logic [31:0] pc;
    logic        valid;
    logic [5:0]  opcode;
    logic [1:0]  wb;
    logic [2:0]  me;
    logic [3:0]  ex;
    logic        uses_rt;
    logic        hazard;
    logic        bubble;

    assign opcode    = instr[31:26];
    assign imem_addr = pc;

    always_comb begin
        wb      = 2'b00;
        me      = 3'b000;
        ex      = 4'b0000;
        uses_rt = 1'b0;
        case (opcode)
            OP_R: begin
                wb      = 2'b11;
                ex      = 4'b0100;
                uses_rt = 1'b1;
            end
            OP_LW: begin
                wb = 2'b10;
                me = 3'b010;
                ex = 4'b1001;
            end
            OP_SW: begin
                me      = 3'b001;
                ex      = 4'b1001;
                uses_rt = 1'b1;
            end
            OP_BEQ: begin
                me      = 3'b100;
                ex      = 4'b0010;
                uses_rt = 1'b1;
            end
            OP_ADDI: begin
                wb = 2'b11;
                ex = 4'b1001;
            end
            default: ;
        endcase
    end

    assign hazard = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == instr[25:21]) ||
                     (uses_rt && (ex_rt == instr[20:16])));

    // A taken branch overrides the stall.
    assign stall  = hazard && !branch_taken && !rst;

    // Flushed or reset IF/ID contents are a bubble, not an R-type word.
    assign bubble = !valid || stall || branch_taken || rst;

    assign WBID = bubble ? 2'b00   : wb;
    assign MEID = bubble ? 3'b000  : me;
    assign EXID = bubble ? 4'b0000 : ex;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            instr       <= 32'h0000_0000;
            valid       <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else if (branch_taken) begin
            pc    <= branch_target;
            instr <= 32'h0000_0000;
            valid <= 1'b0;
            if (flush_count != {CNT_W{1'b1}})
                flush_count <= flush_count + 1'b1;
        end else if (stall) begin
            if (stall_count != {CNT_W{1'b1}})
                stall_count <= stall_count + 1'b1;
        end else begin
            pc    <= pc + 32'd4;
            instr <= imem_data;
            valid <= 1'b1;
        end
    end

endmodule
